multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clk_i and rst_i.
REQ-002 Parameter XLEN, default 32, data width in bits.
REQ-003 Parameter NREGS, default 32, number of registers; AW = $clog2(NREGS).
REQ-004 Parameter NRD, default 2, number of combinational read ports.
REQ-005 Parameter ZERO_REG, default 1; when 1, register 0 reads zero and ignores writes.
REQ-006 Parameter BYPASS, default 1; when 1, same-cycle write data is forwarded to reads.
REQ-007 Ports, in order:
  - clk_i  in  1  clock.
  - rst_i  in  1  synchronous active-high reset.
  - ready_o  out  1  high once the clear sequence is done.
  - we0_i  in  1  write enable, port 0.
  - waddr0_i  in  AW  write address, port 0.
  - wdata0_i  in  XLEN  write data, port 0.
  - we1_i  in  1  write enable, port 1.
  - waddr1_i  in  AW  write address, port 1.
  - wdata1_i  in  XLEN  write data, port 1.
  - raddr_i  in  NRD*AW  packed read addresses; port k is at bits [k*AW +: AW].
  - rdata_o  out  NRD*XLEN  packed read data.
  - rbusy_o  out  NRD  busy bit of each read address.
  - reserve_i  in  1  mark one register pending.
  - reserve_addr_i  in  AW  register to mark.

Function
REQ-008 The block SHALL be a two-state FSM: CLEAR and RUN.
REQ-009 CLEAR SHALL write zero to entry cnt each cycle, with cnt counting 0..NREGS-1, and clear all busy bits.
REQ-010 CLEAR SHALL move to RUN on the cycle after cnt = NREGS-1 is written, so CLEAR lasts exactly NREGS cycles.
REQ-011 In CLEAR: ready_o = 0, all rdata_o = 0, all rbusy_o = 0, and writes and reserves are ignored.
REQ-012 In RUN, ready_o SHALL be 1.
REQ-013 Writes SHALL commit at posedge clk_i when weN_i = 1; the stored value is visible to reads from the next cycle.
REQ-014 If both write ports target the same address in one cycle, port 1's data SHALL be stored.
REQ-015 Reads SHALL be combinational from raddr_i.
REQ-016 With BYPASS = 1, a read whose address matches an active write in the same cycle SHALL return that write's data, port 1 first.
REQ-017 With BYPASS = 0, reads SHALL return the stored value only.
REQ-018 With ZERO_REG = 1, address 0 SHALL always read 0 with busy 0, and writes and reserves to it are dropped.
REQ-019 An address >= NREGS SHALL be ignored on write and reserve, and SHALL read 0 with busy 0.
REQ-020 reserve_i SHALL set busy[reserve_addr_i] at the clock edge.
REQ-021 Any committed write SHALL clear busy[waddr] at the clock edge.
REQ-022 A reserve and a write to the same address in the same cycle SHALL leave the busy bit set (reserve wins).
REQ-023 rbusy_o[k] SHALL show the registered busy bit for raddr k, with no bypass of same-cycle reserve or clear.

Reset
REQ-024 rst_i = 1 at a posedge SHALL force state = CLEAR, cnt = 0, ready_o = 0 and all busy bits = 0.
REQ-025 A reset asserted mid-CLEAR or mid-RUN SHALL restart the full NREGS-cycle clear.
REQ-026 While rst_i is held high, the block SHALL stay in CLEAR with cnt = 0.
REQ-027 No register content SHALL be relied upon before ready_o = 1.

Structure
REQ-028 The state enum (CLEAR, RUN) and default XLEN/NREGS constants SHALL live in shared package regfile_pkg.
REQ-029 The block SHALL be a single module with no sub-modules; the FSM, storage array, busy vector and read muxes are inline.
REQ-030 Storage and busy state SHALL use always_ff only; read and bypass logic SHALL use always_comb or assign.

Verification
REQ-031 Reset held 3 cycles, then released: ready_o = 0 for exactly 32 cycles, then 1; every register reads 0.
REQ-032 Write x5 = 0xDEADBEEF on port 0 while reading x5: with BYPASS = 1, rdata = 0xDEADBEEF in the same cycle; with BYPASS = 0, the old value that cycle and the new value next cycle.
REQ-033 Write x7 = 1 on port 0 and x7 = 2 on port 1 in the same cycle: x7 reads 2 afterwards; a write of 0x55 to x0 still reads 0.
REQ-034 Reserve x9: rbusy = 1 next cycle. Then write x9 with reserve x9 in the same cycle: busy stays 1. Then write x9 alone: busy = 0.
REQ-035 Assert rst_i at cycle 10 of RUN after writing x3 = 0x1234: ready_o drops next cycle, x3 reads 0 after the clear, and rbusy_o = 0.
REQ-036 NREGS = 24 build: a write to address 30 is ignored, and address 30 reads 0 with busy 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multiport register file: the controller state
// encoding and the default data width / register count.
// ---------------------------------------------------------------------------
package regfile_pkg;

    // Controller states: CLEAR walks every entry to zero, RUN is normal use.
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_e;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

endpackage

// File: rtl/multiport_register_file.sv
// ---------------------------------------------------------------------------
// multiport_register_file
// Register file with two write ports, NRD combinational read ports and a
// per-register busy (pending) bit. After reset, a clear sequence zeroes one
// entry per cycle for NREGS cycles. The outputs are held at zero until that
// sequence finishes and ready_o goes high.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous active-high reset (restarts the clear)
//   ready_o         high once the clear sequence has finished
//   we0_i/waddr0_i/wdata0_i   write port 0
//   we1_i/waddr1_i/wdata1_i   write port 1 (wins on an address collision)
//   raddr_i         packed read addresses, port k at [k*AW +: AW]
//   rdata_o         packed read data, port k at [k*XLEN +: XLEN]
//   rbusy_o         registered busy bit of each read address
//   reserve_i       set the busy bit of reserve_addr_i
//   reserve_addr_i  register to mark pending
// ---------------------------------------------------------------------------
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int   XLEN     = DEF_XLEN,
    parameter int   NREGS    = DEF_NREGS,
    parameter int   NRD      = 2,
    parameter bit   ZERO_REG = 1'b1,
    parameter bit   BYPASS   = 1'b1,
    localparam int  AW       = $clog2(NREGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    output logic                 ready_o,
    input  logic                 we0_i,
    input  logic [AW-1:0]        waddr0_i,
    input  logic [XLEN-1:0]      wdata0_i,
    input  logic                 we1_i,
    input  logic [AW-1:0]        waddr1_i,
    input  logic [XLEN-1:0]      wdata1_i,
    input  logic [NRD*AW-1:0]    raddr_i,
    output logic [NRD*XLEN-1:0]  rdata_o,
    output logic [NRD-1:0]       rbusy_o,
    input  logic                 reserve_i,
    input  logic [AW-1:0]        reserve_addr_i
);

    // One extra bit so that NREGS itself is representable for the range test.
    localparam logic [AW:0]   NREGS_L  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    // An address is usable if it is inside the array and is not the
    // hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] addr);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, addr} < NREGS_L);
        is_zero  = ZERO_REG && (addr == {AW{1'b0}});
        return in_range && !is_zero;
    endfunction

    rf_state_e              state_r;
    rf_state_e              state_next_s;
    logic [AW-1:0]          cnt_r;
    logic                   ready_r;
    logic                   clear_en_s;
    logic                   run_en_s;
    logic                   wr0_ok_s;
    logic                   wr1_ok_s;
    logic                   rsv_ok_s;
    logic [XLEN-1:0]        mem_r [NREGS];
    logic [NREGS-1:0]       busy_r;
    logic [NRD*XLEN-1:0]    rdata_s;
    logic [NRD-1:0]         rbusy_s;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: leave CLEAR once the last entry has been zeroed.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (cnt_r == LAST_IDX) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_CLEAR;
        endcase
    end

    // State decode into datapath enables.
    always_comb begin
        clear_en_s = 1'b0;
        run_en_s   = 1'b0;
        case (state_r)
            ST_CLEAR: clear_en_s = 1'b1;
            ST_RUN:   run_en_s   = 1'b1;
            default:  clear_en_s = 1'b1;
        endcase
    end

    // ready_o is registered and tracks the RUN state exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= (state_next_s == ST_RUN);
        end
    end

    assign ready_o = ready_r;

    // Clear pointer: walks 0..NREGS-1 while clearing and rests at 0 otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {AW{1'b0}};
        end else if (clear_en_s && (cnt_r != LAST_IDX)) begin
            cnt_r <= cnt_r + AW'(1);
        end else begin
            cnt_r <= {AW{1'b0}};
        end
    end

    // Writes and reserves only take effect in RUN and to usable addresses.
    assign wr0_ok_s = run_en_s && we0_i && addr_ok(waddr0_i);
    assign wr1_ok_s = run_en_s && we1_i && addr_ok(waddr1_i);
    assign rsv_ok_s = run_en_s && reserve_i && addr_ok(reserve_addr_i);

    // Storage: zero one entry per cycle while clearing, otherwise commit the
    // writes. Port 1 is assigned last, so it wins on an address collision.
    always_ff @(posedge clk_i) begin
        if (clear_en_s) begin
            mem_r[cnt_r] <= {XLEN{1'b0}};
        end else begin
            if (wr0_ok_s) begin
                mem_r[waddr0_i] <= wdata0_i;
            end
            if (wr1_ok_s) begin
                mem_r[waddr1_i] <= wdata1_i;
            end
        end
    end

    // Busy bits: writes clear and reserves set. The reserve is assigned last,
    // so it wins when both hit the same register.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_en_s) begin
            busy_r <= {NREGS{1'b0}};
        end else begin
            if (wr0_ok_s) begin
                busy_r[waddr0_i] <= 1'b0;
            end
            if (wr1_ok_s) begin
                busy_r[waddr1_i] <= 1'b0;
            end
            if (rsv_ok_s) begin
                busy_r[reserve_addr_i] <= 1'b1;
            end
        end
    end

    // Read muxes with optional same-cycle forwarding (port 1 first). Busy is
    // never forwarded.
    always_comb begin
        rdata_s = {(NRD*XLEN){1'b0}};
        rbusy_s = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            if (run_en_s && addr_ok(raddr_i[k*AW +: AW])) begin
                rbusy_s[k] = busy_r[raddr_i[k*AW +: AW]];
                if (BYPASS && wr1_ok_s && (waddr1_i == raddr_i[k*AW +: AW])) begin
                    rdata_s[k*XLEN +: XLEN] = wdata1_i;
                end else if (BYPASS && wr0_ok_s && (waddr0_i == raddr_i[k*AW +: AW])) begin
                    rdata_s[k*XLEN +: XLEN] = wdata0_i;
                end else begin
                    rdata_s[k*XLEN +: XLEN] = mem_r[raddr_i[k*AW +: AW]];
                end
            end else begin
                rbusy_s[k]              = 1'b0;
                rdata_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end
        end
    end

    assign rdata_o = rdata_s;
    assign rbusy_o = rbusy_s;

endmodule

// File: tb/tb_multiport_register_file.sv
// ---------------------------------------------------------------------------
// tb_multiport_register_file
// Drives two register files from the same stimulus: A is the default build
// (32 registers, forwarding on) and B has 24 registers with forwarding off.
// A behavioural model predicts every cycle's outputs. The stimulus process
// queues each prediction, and a monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_multiport_register_file;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NRD  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic                we0, we1, reserve;
    logic [AW-1:0]       waddr0, waddr1, resaddr;
    logic [XLEN-1:0]     wdata0, wdata1;
    logic [NRD*AW-1:0]   raddr;
    logic                ready_a, ready_b;
    logic [NRD*XLEN-1:0] rdata_a, rdata_b;
    logic [NRD-1:0]      rbusy_a, rbusy_b;

    multiport_register_file #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .ready_o(ready_a),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .raddr_i(raddr), .rdata_o(rdata_a), .rbusy_o(rbusy_a),
        .reserve_i(reserve), .reserve_addr_i(resaddr)
    );

    multiport_register_file #(.XLEN(32), .NREGS(24), .NRD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .ready_o(ready_b),
        .we0_i(we0), .waddr0_i(waddr0), .wdata0_i(wdata0),
        .we1_i(we1), .waddr1_i(waddr1), .wdata1_i(wdata1),
        .raddr_i(raddr), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
        .reserve_i(reserve), .reserve_addr_i(resaddr)
    );

    // ---------------- reference model ----------------
    int          nregs_m [2] = '{32, 24};
    bit          byp_m   [2] = '{1'b1, 1'b0};
    logic [31:0] mem_m   [2][32];
    bit          busy_m  [2][32];
    int          clr_left [2];
    bit          model_valid = 1'b0;

    typedef struct {
        logic [63:0] rd_a;
        logic [1:0]  bz_a;
        logic        rdy_a;
        logic [63:0] rd_b;
        logic [1:0]  bz_b;
        logic        rdy_b;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic bit usable(input int c, input int a);
        return (a != 0) && (a < nregs_m[c]);
    endfunction

    function automatic void exp_read(input int c, input int a, output logic [31:0] d, output logic b);
        d = 32'h0;
        b = 1'b0;
        if (clr_left[c] == 0 && usable(c, a)) begin
            d = mem_m[c][a];
            b = busy_m[c][a];
            if (byp_m[c]) begin
                if (we1 && int'(waddr1) == a) d = wdata1;
                else if (we0 && int'(waddr0) == a) d = wdata0;
            end
        end
    endfunction

    function automatic exp_t predict();
        exp_t        e;
        logic [31:0] d;
        logic        b;
        for (int k = 0; k < NRD; k++) begin
            exp_read(0, int'(raddr[k*AW +: AW]), d, b);
            e.rd_a[k*32 +: 32] = d;
            e.bz_a[k] = b;
            exp_read(1, int'(raddr[k*AW +: AW]), d, b);
            e.rd_b[k*32 +: 32] = d;
            e.bz_b[k] = b;
        end
        e.rdy_a = (clr_left[0] == 0);
        e.rdy_b = (clr_left[1] == 0);
        return e;
    endfunction

    // Apply one clock edge to the model using the current inputs.
    function automatic void model_edge();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                clr_left[c] = nregs_m[c];
                for (int i = 0; i < 32; i++) begin
                    mem_m[c][i]  = 32'h0;
                    busy_m[c][i] = 1'b0;
                end
            end else if (clr_left[c] > 0) begin
                clr_left[c] = clr_left[c] - 1;
                for (int i = 0; i < 32; i++) busy_m[c][i] = 1'b0;
            end else begin
                if (we0 && usable(c, int'(waddr0))) begin
                    mem_m[c][waddr0]  = wdata0;
                    busy_m[c][waddr0] = 1'b0;
                end
                if (we1 && usable(c, int'(waddr1))) begin
                    mem_m[c][waddr1]  = wdata1;
                    busy_m[c][waddr1] = 1'b0;
                end
                if (reserve && usable(c, int'(resaddr))) busy_m[c][resaddr] = 1'b1;
            end
        end
    endfunction

    // ---------------- monitor ----------------
    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ready_a", {63'h0, ready_a}, {63'h0, e.rdy_a});
            chk("rdata_a", rdata_a, e.rd_a);
            chk("rbusy_a", {62'h0, rbusy_a}, {62'h0, e.bz_a});
            chk("ready_b", {63'h0, ready_b}, {63'h0, e.rdy_b});
            chk("rdata_b", rdata_b, e.rd_b);
            chk("rbusy_b", {62'h0, rbusy_b}, {62'h0, e.bz_b});
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        if (model_valid) exp_q.push_back(predict());
        @(posedge clk);
        if (rst) model_valid = 1'b1;
        if (model_valid) model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; we0 = 1'b0; we1 = 1'b0; reserve = 1'b0;
        waddr0 = 5'd0; waddr1 = 5'd0; resaddr = 5'd0;
        wdata0 = 32'h0; wdata1 = 32'h0; raddr = 10'd0;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a0);
        raddr = {a1, a0};
    endtask

    initial begin
        idle();
        // Reset held three cycles, then the clear sequence.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        for (int i = 0; i < 34; i++) begin
            rd(5'(i % 32), 5'((i * 7) % 32));
            step();
        end
        // Every register reads zero after the clear.
        for (int i = 0; i < 16; i++) begin
            rd(5'(2 * i + 1), 5'(2 * i));
            step();
        end
        // Same-cycle forwarding of a write to x5.
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; rd(5'd5, 5'd5);
        step();
        idle(); rd(5'd5, 5'd5);
        step();
        // Both ports write x7; port 1 wins. Writes to x0 are dropped.
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'd1;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'd2; rd(5'd7, 5'd0);
        step();
        idle(); rd(5'd7, 5'd0);
        step();
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'h55; rd(5'd0, 5'd0);
        step();
        idle(); rd(5'd0, 5'd7);
        step();
        // Reserve x9, then write and reserve together, then write alone.
        reserve = 1'b1; resaddr = 5'd9; rd(5'd9, 5'd9);
        step();
        idle(); rd(5'd9, 5'd9);
        step();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h99; reserve = 1'b1; resaddr = 5'd9; rd(5'd9, 5'd9);
        step();
        idle(); rd(5'd9, 5'd9);
        step();
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h9A; rd(5'd9, 5'd9);
        step();
        idle(); rd(5'd9, 5'd9);
        step();
        // Write x3, run a few cycles, then reset mid-RUN.
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h1234; reserve = 1'b1; resaddr = 5'd4; rd(5'd3, 5'd4);
        step();
        idle(); rd(5'd3, 5'd4);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (36) step();
        // Address 30 exists in A only.
        we0 = 1'b1; waddr0 = 5'd30; wdata0 = 32'hCAFE0030; reserve = 1'b1; resaddr = 5'd30; rd(5'd30, 5'd30);
        step();
        idle(); rd(5'd30, 5'd23);
        step();
        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(0, 399) == 0);
            we0     = $urandom_range(0, 1) == 1;
            we1     = $urandom_range(0, 2) == 0;
            reserve = $urandom_range(0, 2) == 0;
            waddr0  = 5'($urandom_range(0, 31));
            waddr1  = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
            resaddr = ($urandom_range(0, 3) == 0) ? waddr0 : 5'($urandom_range(0, 31));
            wdata0  = $urandom();
            wdata1  = $urandom();
            raddr   = {($urandom_range(0, 1) == 1) ? waddr1 : 5'($urandom_range(0, 31)),
                       ($urandom_range(0, 1) == 1) ? waddr0 : 5'($urandom_range(0, 31))};
            step();
        end
        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
